// File: rtl/mandelbrot_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mandelbrot_pkg
//  Description : Shared constants and types for the Mandelbrot render block.
//                Holds the configuration word length and the bit layout of
//                the committed configuration word.
//  Ports       : (package, none)
//  Revision    : 1.0  initial release
// ============================================================================
package mandelbrot_pkg;

   localparam int CFG_WIDTH = 33;

   // Field positions inside the configuration word (LSB .. MSB)
   localparam int CR_OFFSET_LSB  = 0;
   localparam int CR_OFFSET_MSB  = 10;
   localparam int CI_OFFSET_LSB  = 11;
   localparam int CI_OFFSET_MSB  = 21;
   localparam int SCALING_LSB    = 22;
   localparam int SCALING_MSB    = 23;
   localparam int CTR_SELECT_LSB = 24;
   localparam int CTR_SELECT_MSB = 25;
   localparam int MAX_CTR_LSB    = 26;
   localparam int MAX_CTR_MSB    = 32;

   // Packed view of the word; first member lands in the MSBs
   typedef struct packed {
      logic [6:0]  max_ctr;
      logic [1:0]  ctr_select;
      logic [1:0]  scaling;
      logic [10:0] ci_offset;
      logic [10:0] cr_offset;
   } cfg_word_t;

endpackage : mandelbrot_pkg
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : sync_edge
//  Description : Multi-flop synchronizer for one asynchronous input, plus a
//                history flop so rising/falling edges of the synchronized
//                level can be detected.
//  Ports       : clk, reset      - clock / synchronous active-high reset
//                i_async         - asynchronous input
//                o_level         - synchronized level
//                o_rise, o_fall  - one-cycle edge strobes of o_level
//  Revision    : 1.0  initial release
// ============================================================================
module sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic i_async,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_hist;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync <= '0;
         r_hist <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
         r_hist <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_level = r_sync[SYNC_STAGES-1];
   assign o_rise  =  r_sync[SYNC_STAGES-1] & ~r_hist;
   assign o_fall  = ~r_sync[SYNC_STAGES-1] &  r_hist;

endmodule : sync_edge
`default_nettype wire

// File: rtl/cfg_serial_rx.sv
`default_nettype none
// ============================================================================
//  Module      : cfg_serial_rx
//  Description : Serial configuration receiver. Shifts in an LSB-first word
//                framed by sen_in and clocked by sclk_in, checks the bit
//                count at frame end and commits the word to cfg_out, holding
//                it back while the render engine is busy.
//  Ports       : clk, reset          - clock / synchronous active-high reset
//                sen_in, sclk_in,
//                sdata_in            - asynchronous serial frame inputs
//                busy                - render engine running, defers commit
//                cfg_out             - committed configuration word
//                start               - pulse on each commit
//                frame_err           - pulse on a bad bit count
//                pending             - a valid word awaits busy low
//  Revision    : 1.0  initial release
// ============================================================================
module cfg_serial_rx
   import mandelbrot_pkg::*;
#(
   parameter int CFG_WIDTH   = mandelbrot_pkg::CFG_WIDTH,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 sen_in,
   input  logic                 sclk_in,
   input  logic                 sdata_in,
   input  logic                 busy,
   output logic [CFG_WIDTH-1:0] cfg_out,
   output logic                 start,
   output logic                 frame_err,
   output logic                 pending
);

   localparam int CW = $clog2(CFG_WIDTH + 2);
   localparam int FW = $clog2(SYNC_STAGES + 2);

   localparam logic [CW-1:0] c_cnt_full = CW'(CFG_WIDTH);
   localparam logic [CW-1:0] c_cnt_sat  = CW'(CFG_WIDTH + 1);
   localparam logic [FW-1:0] c_flush    = FW'(SYNC_STAGES + 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RX   = 1'b1;

   logic w_sen_level,  w_sen_rise,  w_sen_fall;
   logic w_sclk_level, w_sclk_rise, w_sclk_fall;
   logic w_sdata_level, w_sdata_rise, w_sdata_fall;
   logic w_unused_edges;
   logic w_flush_done;
   logic w_frame_end;

   logic [0:0]           r_state;
   logic [CW-1:0]        r_bit_cnt;
   logic [CFG_WIDTH-1:0] r_shift;
   logic [CFG_WIDTH-1:0] r_hold;
   logic [CFG_WIDTH-1:0] r_cfg;
   logic                 r_start;
   logic                 r_frame_err;
   logic                 r_frame_valid;
   logic                 r_pending;
   logic [FW-1:0]        r_flush_cnt;
   logic                 r_armed;

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sen (
      .clk(clk), .reset(reset), .i_async(sen_in),
      .o_level(w_sen_level), .o_rise(w_sen_rise), .o_fall(w_sen_fall)
   );

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
      .clk(clk), .reset(reset), .i_async(sclk_in),
      .o_level(w_sclk_level), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
   );

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdata (
      .clk(clk), .reset(reset), .i_async(sdata_in),
      .o_level(w_sdata_level), .o_rise(w_sdata_rise), .o_fall(w_sdata_fall)
   );

   assign w_unused_edges = w_sclk_level | w_sclk_fall | w_sdata_rise | w_sdata_fall;

   // The synchronizers restart from 0 after reset, so a sen_in that stayed
   // high would look like a fresh rising edge. Frames are only accepted once
   // the pipeline holds real samples and sen has been seen low.
   assign w_flush_done = (r_flush_cnt == c_flush);

   // While a frame end is being classified, frame_err may fire this edge;
   // a deferred commit waits one cycle so start and frame_err never overlap.
   assign w_frame_end = (r_state == S_RX) && w_sen_fall;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_bit_cnt     <= '0;
         r_shift       <= '0;
         r_hold        <= '0;
         r_cfg         <= '0;
         r_start       <= 1'b0;
         r_frame_err   <= 1'b0;
         r_frame_valid <= 1'b0;
         r_pending     <= 1'b0;
         r_flush_cnt   <= '0;
         r_armed       <= 1'b0;
      end else begin
         r_start       <= 1'b0;
         r_frame_err   <= 1'b0;
         r_frame_valid <= 1'b0;

         if (!w_flush_done) begin
            r_flush_cnt <= r_flush_cnt + FW'(1);
         end
         if (w_flush_done && !w_sen_level) begin
            r_armed <= 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               if (w_sen_rise && r_armed) begin
                  r_state   <= S_RX;
                  r_bit_cnt <= '0;
               end
            end
            S_RX: begin
               if (w_sen_fall) begin
                  r_state <= S_IDLE;
                  if (r_bit_cnt == c_cnt_full) begin
                     r_frame_valid <= 1'b1;
                  end else begin
                     r_frame_err <= 1'b1;
                  end
               end else if (w_sen_level && w_sclk_rise) begin
                  r_shift <= {w_sdata_level, r_shift[CFG_WIDTH-1:1]};
                  if (r_bit_cnt != c_cnt_sat) begin
                     r_bit_cnt <= r_bit_cnt + CW'(1);
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase

         // Commit path. A new valid word always supersedes a held one, so at
         // most one start follows however many frames arrive while busy.
         if (r_frame_valid) begin
            if (!busy) begin
               r_cfg     <= r_shift;
               r_start   <= 1'b1;
               r_pending <= 1'b0;
            end else begin
               r_hold    <= r_shift;
               r_pending <= 1'b1;
            end
         end else if (r_pending && !busy && !w_frame_end) begin
            r_cfg     <= r_hold;
            r_start   <= 1'b1;
            r_pending <= 1'b0;
         end
      end
   end

   assign cfg_out   = r_cfg;
   assign start     = r_start;
   assign frame_err = r_frame_err;
   assign pending   = r_pending;

endmodule : cfg_serial_rx
`default_nettype wire

// File: doc/cfg_serial_rx.md
CFG_SERIAL_RX -- requirements
Module: cfg_serial_rx

Interface
REQ-001 SHALL have parameter CFG_WIDTH, default 33: configuration word length in bits.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer flops per serial input, minimum 2.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port sen_in  input  1  asynchronous frame enable; a frame lasts while high.
REQ-006 SHALL have port sclk_in  input  1  asynchronous serial clock; data sampled on its rising edge.
REQ-007 SHALL have port sdata_in  input  1  asynchronous serial data, LSB first.
REQ-008 SHALL have port busy  input  1  high while the render engine is running; holds off commit.
REQ-009 SHALL have port cfg_out  output  CFG_WIDTH  committed configuration word, registered.
REQ-010 SHALL have port start  output  1  one-cycle pulse when a new word is committed to cfg_out.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse when a frame ends with the wrong bit count.
REQ-012 SHALL have port pending  output  1  high while a valid word waits for busy to drop.

Function
REQ-013 SHALL pass sen_in, sclk_in and sdata_in through SYNC_STAGES-deep synchronizers, plus one history flop on sen and sclk for edge detection.
REQ-014 SHALL run receiver FSM IDLE -> RX on synchronized sen rising edge; RX -> IDLE on synchronized sen falling edge.
REQ-015 SHALL, on entry to RX, clear the bit counter to 0.
REQ-016 SHALL, in RX with synchronized sen high and a synchronized sclk rising edge detected, shift: shift_reg <= {sdata_s, shift_reg[CFG_WIDTH-1:1]}; counter increments.
REQ-017 SHALL saturate the bit counter at CFG_WIDTH+1; further edges keep shifting without counter wrap.
REQ-018 SHALL ignore sclk edges in IDLE.
REQ-019 SHALL, on RX -> IDLE with counter == CFG_WIDTH, classify the frame as valid; otherwise pulse frame_err for exactly one cycle and discard it; cfg_out and pending unchanged.
REQ-020 SHALL, on a valid frame with busy low, load cfg_out from shift_reg and pulse start on the following clock edge.
REQ-021 SHALL, on a valid frame with busy high, copy shift_reg into a hold register and set pending.
REQ-022 SHALL, while pending and busy low, load cfg_out from hold, pulse start and clear pending on the same edge.
REQ-023 SHALL, on a new valid frame while pending, overwrite hold with the newer word; exactly one start pulse follows.
REQ-024 SHALL give a latency of SYNC_STAGES+2 clk cycles from the first edge sampling sen_in low to start high (busy low).
REQ-025 SHALL keep cfg_out stable between start pulses; start and frame_err are never high together.
REQ-026 SHALL treat a frame of zero sclk edges as an error (counter 0 != CFG_WIDTH).

Reset
REQ-027 SHALL, with reset high at a clk edge, clear synchronizers, history flops, shift_reg, hold, counter, cfg_out, start, frame_err and pending to 0, and place the FSM in IDLE.
REQ-028 SHALL abort a frame in progress on reset, with no start and no frame_err; a sen_in still high after reset release is not a new frame until it falls and rises again.

Structure
REQ-029 SHALL take CFG_WIDTH and the cfg_out field offsets (cr_offset [10:0], ci_offset [21:11], scaling [23:22], ctr_select [25:24], max_ctr [32:26]) from a shared package, mandelbrot_pkg.
REQ-030 SHALL implement the synchronizer as one reusable sub-module, sync_edge, instantiated per input, outputting level, rise and fall.

Verification
REQ-031 SHALL cover: reset, then a 33-bit frame of 0x1_2345_6789 LSB first, busy=0 -> cfg_out=0x1_2345_6789, one start pulse, frame_err=0.
REQ-032 SHALL cover: a 32-bit frame -> frame_err one cycle, cfg_out unchanged, no start; same for 34 bits.
REQ-033 SHALL cover: busy=1, valid frame 0x0_0000_00FF -> pending=1, cfg_out unchanged; busy falls -> start one cycle, cfg_out=0xFF, pending=0.
REQ-034 SHALL cover: busy=1, frames 0xAAA then 0x555 -> after busy falls, a single start and cfg_out=0x555.
REQ-035 SHALL cover: reset after 20 bits, frame then completed -> no start, no frame_err, cfg_out=0.
REQ-036 SHALL cover: sclk toggling with sen low -> no shift, outputs unchanged.
